exception_unit: RTL
===================

Name: exception_unit

Overview:
- Parametrised successor to the writeback-stage overflow/exception override. Sits between the ALU/multdiv results and register-file writeback.
- On an unmasked exception, it redirects the write to the status register and substitutes a priority-encoded exception code.
- Also logs each unmasked exception (code + PC) into a small FIFO, raises an irq line and keeps a saturating event counter, so handler logic can drain events with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, width of writeback data and PC.
- REG_ADDR_WIDTH, 5, register address width.
- STATUS_REG, 30, register index that receives exception codes.
- CODE_WIDTH, 4, exception code width.
- DEPTH, 4, exception log FIFO entries (power of 2, ≥2).
- COUNT_WIDTH, 16, saturating exception counter width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  writeback slot carries a real instruction
- overflow  in  1  ALU overflow for this instruction
- md_exception  in  1  multdiv exception (div-by-zero / mult overflow)
- rType  in  1  instruction is R-type
- aluOp  in  5  ALU opcode
- exc_mask  in  2^CODE_WIDTH  bit n=1 masks code n
- rdIn  in  REG_ADDR_WIDTH  destination register
- dIn  in  DATA_WIDTH  writeback data
- pcIn  in  DATA_WIDTH  PC of writeback instruction
- rdOut  out  REG_ADDR_WIDTH  final destination
- dOut  out  DATA_WIDTH  final data
- exc_taken  out  1  this cycle's instruction was redirected
- exc_valid  out  1  FIFO head valid
- exc_code  out  CODE_WIDTH  head code
- exc_pc  out  DATA_WIDTH  head PC
- exc_ready  in  1  consumer pops head when exc_valid & exc_ready
- irq  out  1  registered, = FIFO non-empty
- exc_dropped  out  1  sticky: an event was lost to a full FIFO
- clear_dropped  in  1  clears exc_dropped
- exc_count  out  COUNT_WIDTH  saturating count of taken exceptions

Behaviour:
- Raw event: raw = wb_valid & (overflow | md_exception).
- Code selection (priority high to low):
  - add: rType & aluOp==0 → code 1
  - addi: ~rType & aluOp==0 → code 2
  - sub: aluOp==1 → code 3
  - mul: aluOp==6 → code 4
  - div: aluOp==7 → code 5
  - otherwise → code 0, treated as no exception.
- Taken: exc_taken = raw & code!=0 & ~exc_mask[code]. Combinational, zero latency.
- Redirect: if exc_taken, rdOut=STATUS_REG and dOut=zero-extended code. Otherwise rdOut=rdIn and dOut=dIn unchanged. Masked or code-0 events pass through unchanged.
- Log push = exc_taken, pushing {code, pcIn}. Entry is visible on exc_valid on the next rising edge.
- Pop = exc_valid & exc_ready. exc_code/exc_pc are driven from the head combinationally and are stable while exc_valid & ~exc_ready.
- Full FIFO:
  - push & pop in the same cycle: both succeed, occupancy unchanged.
  - push without pop: entry dropped, exc_dropped set next edge, FIFO contents unchanged.
- Empty FIFO: pop is ignored. Push & pop while empty: push only.
- Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- exc_dropped: set dominates clear_dropped when both occur in the same cycle.
- exc_count: +1 per exc_taken, holds at all-ones.
- irq: registered copy of "occupancy after this edge != 0".
- Reset (synchronous, active-high): empties FIFO, clears exc_dropped, exc_count, irq; exc_valid=0. rdOut/dOut stay combinational passthrough/override during reset. No push is recorded in a reset cycle, including mid-drain.
- exc_mask changes take effect in the same cycle. Entries already logged are not affected.

Decomposition:
- Shared package holds:
  - exception code constants EXC_NONE=0, EXC_ADD=1, EXC_ADDI=2, EXC_SUB=3, EXC_MUL=4, EXC_DIV=5
  - ALU opcode constants ALU_ADD=0, ALU_SUB=1, ALU_MUL=6, ALU_DIV=7
  - STATUS_REG default
- One natural sub-module: exc_fifo, a parametrised DATA/DEPTH sync FIFO with valid/ready pop, a push_dropped output and synchronous reset.
- Code priority encoder and counter stay inline.

Test Plan:
- Overflow, rType=1, aluOp=0, rdIn=7, dIn=0x1234, mask=0 → same cycle rdOut=30, dOut=1, exc_taken=1. Next cycle exc_valid=1, exc_code=1, exc_pc=pcIn, irq=1, exc_count=1.
- md_exception, aluOp=7 with exc_mask[5]=1 → rdOut=rdIn, dOut=dIn, exc_taken=0, no FIFO entry, exc_count unchanged.
- Five back-to-back taken events with exc_ready=0 (DEPTH=4) → 4 entries in order; 5th dropped, exc_dropped=1. Then clear_dropped with no push → exc_dropped=0.
- Full FIFO with simultaneous taken event and exc_ready=1 → head popped, new entry at tail, occupancy stays 4, exc_dropped stays 0.
- Drain with exc_ready held 1 → codes appear in push order one per cycle; irq falls on the edge after the last pop.
- Reset asserted mid-drain with a taken event in the same cycle → next cycle exc_valid=0, irq=0, exc_count=0, no entry recorded. exc_count saturation with COUNT_WIDTH=2 holds at 3.

Source files
------------

// File: rtl/exception_unit_pkg.sv
// exception_unit_pkg: shared exception codes, ALU opcodes and defaults for the writeback exception unit.
package exception_unit_pkg;
  localparam int ALU_OP_WIDTH = 5;
  localparam int STATUS_REG_DEF = 30;
  localparam int EXC_NONE = 0;
  localparam int EXC_ADD = 1;
  localparam int EXC_ADDI = 2;
  localparam int EXC_SUB = 3;
  localparam int EXC_MUL = 4;
  localparam int EXC_DIV = 5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 5'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 5'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL = 5'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV = 5'd7;
endpackage

// File: rtl/exception_unit_if.sv
// exception_unit_if: exception log drain handshake.
//   master (exception unit): drives exc_valid, exc_code, exc_pc; samples exc_ready.
//   slave  (handler logic) : samples the head; drives exc_ready to pop it.
interface exception_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CODE_WIDTH = 4
);
  logic exc_valid;
  logic exc_ready;
  logic [CODE_WIDTH-1:0] exc_code;
  logic [DATA_WIDTH-1:0] exc_pc;
  modport master (output exc_valid, exc_code, exc_pc, input exc_ready);
  modport slave (input exc_valid, exc_code, exc_pc, output exc_ready);
endinterface

// File: rtl/exception_unit_fifo.sv
// exc_fifo: synchronous FIFO with valid/ready pop and a drop indicator for pushes into a full FIFO.
//   clock, reset       : clock, synchronous active-high reset (empties the FIFO)
//   push, pushData     : write request and data
//   popReady           : pops the head when outValid is high
//   outValid, outData  : head entry, combinational from storage
//   pushDropped        : push refused this cycle (full and no simultaneous pop)
//   countNext          : occupancy after the coming edge
module exc_fifo #(
  parameter int DATA_W = 36,
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic [DATA_W-1:0] pushData,
  input  logic popReady,
  output logic outValid,
  output logic [DATA_W-1:0] outData,
  output logic pushDropped,
  output logic [$clog2(DEPTH):0] countNext
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] count;
  logic full, doPop, doPush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    outValid = count != '0;
    doPop = popReady & outValid;
    doPush = push & (~full | doPop);
    pushDropped = push & full & ~doPop;
    countNext = count + (AW+1)'(doPush) - (AW+1)'(doPop);
    outData = mem[rdPtr];
  end
  always_ff @(posedge clock)
    if (doPush) mem[wrPtr] <= pushData;
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop) rdPtr <= rdPtr + AW'(1);
      count <= countNext;
    end
  end
endmodule

// File: rtl/exception_unit.sv
// exception_unit: writeback exception override with event log, irq, drop flag and saturating counter.
//   clock, reset          : clock, synchronous active-high reset
//   wb_valid, overflow, md_exception, rType, aluOp : raw event and instruction class
//   exc_mask              : bit n masks exception code n
//   rdIn, dIn, pcIn       : incoming writeback slot
//   rdOut, dOut           : final writeback (status register + code when redirected)
//   exc_taken             : this cycle's instruction was redirected
//   excBus                : log head (exc_valid/exc_code/exc_pc) and consumer exc_ready
//   irq                   : registered, log non-empty
//   exc_dropped           : sticky, an event was lost to a full log; clear_dropped clears it
//   exc_count             : saturating count of taken exceptions
module exception_unit import exception_unit_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STATUS_REG = STATUS_REG_DEF,
  parameter int CODE_WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic wb_valid,
  input  logic overflow,
  input  logic md_exception,
  input  logic rType,
  input  logic [ALU_OP_WIDTH-1:0] aluOp,
  input  logic [2**CODE_WIDTH-1:0] exc_mask,
  input  logic [REG_ADDR_WIDTH-1:0] rdIn,
  input  logic [DATA_WIDTH-1:0] dIn,
  input  logic [DATA_WIDTH-1:0] pcIn,
  output logic [REG_ADDR_WIDTH-1:0] rdOut,
  output logic [DATA_WIDTH-1:0] dOut,
  output logic exc_taken,
  exception_unit_if.master excBus,
  output logic irq,
  output logic exc_dropped,
  input  logic clear_dropped,
  output logic [COUNT_WIDTH-1:0] exc_count
);
  logic [CODE_WIDTH-1:0] code;
  logic raw, pushDropped;
  logic [$clog2(DEPTH):0] countNext;
  always_comb begin
    code = (aluOp == ALU_ADD) ? (rType ? CODE_WIDTH'(EXC_ADD) : CODE_WIDTH'(EXC_ADDI)) :
           (aluOp == ALU_SUB) ? CODE_WIDTH'(EXC_SUB) :
           (aluOp == ALU_MUL) ? CODE_WIDTH'(EXC_MUL) :
           (aluOp == ALU_DIV) ? CODE_WIDTH'(EXC_DIV) : CODE_WIDTH'(EXC_NONE);
    raw = wb_valid & (overflow | md_exception);
    exc_taken = raw & (code != CODE_WIDTH'(EXC_NONE)) & ~exc_mask[code];
    rdOut = exc_taken ? REG_ADDR_WIDTH'(STATUS_REG) : rdIn;
    dOut = exc_taken ? DATA_WIDTH'(code) : dIn;
  end
  exc_fifo #(.DATA_W(CODE_WIDTH + DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(exc_taken & ~reset),
    .pushData({code, pcIn}),
    .popReady(excBus.exc_ready),
    .outValid(excBus.exc_valid),
    .outData({excBus.exc_code, excBus.exc_pc}),
    .pushDropped(pushDropped),
    .countNext(countNext)
  );
  // A new drop in the same cycle as clear_dropped keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      exc_dropped <= 1'b0;
      exc_count <= '0;
      irq <= 1'b0;
    end else begin
      exc_dropped <= pushDropped | (exc_dropped & ~clear_dropped);
      if (exc_taken & ~&exc_count) exc_count <= exc_count + COUNT_WIDTH'(1);
      irq <= countNext != '0;
    end
  end
endmodule
